// File: rtl/macc_stream_pkg.sv
// Shared types for the MACC matrix stream receive path: framer states,
// framing error codes and the tagged element layout.
package macc_stream_pkg;

  localparam int ELEM_DATA_W = 16;
  localparam int ELEM_DIM_W  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESYNC = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    EOL_EARLY   = 2'd0,
    EOL_MISSING = 2'd1,
    EOM_EARLY   = 2'd2,
    EOM_MISSING = 2'd3
  } frm_err_e;

  typedef struct packed {
    logic [ELEM_DATA_W-1:0] data;
    logic [ELEM_DIM_W-1:0]  row;
    logic [ELEM_DIM_W-1:0]  col;
    logic                   sof;
    logic                   eof;
  } rx_elem_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer with registered valid, ready and data, so the
// producer side never sees a combinational path from the consumer.
module stream_skid_buf #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         ready,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [1:0]   count_r;
  logic [1:0]   count_s;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         ready_r;
  logic         valid_r;
  logic         push_s;
  logic         pop_s;

  assign push_s    = push_valid && ready_r;
  assign pop_s     = valid_r && pop_ready;
  assign ready     = ready_r;
  assign pop_valid = valid_r;
  assign pop_data  = head_r;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + 2'd1;
    end else if (!push_s && pop_s) begin
      count_s = count_r - 2'd1;
    end else begin
      count_s = count_r;
    end
  end

  // Head entry is always the presented beat; tail only fills under backpressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r <= 2'd0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
    end else begin
      count_r <= count_s;
      ready_r <= (count_s != 2'd2);
      valid_r <= (count_s != 2'd0);
      if (pop_s) begin
        if (count_r == 2'd2) begin
          head_r <= tail_r;
          if (push_s) begin
            tail_r <= push_data;
          end
        end else if (push_s) begin
          head_r <= push_data;
        end
      end else if (push_s) begin
        if (count_r == 2'd0) begin
          head_r <= push_data;
        end else begin
          tail_r <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_stream_rx.sv
// Receive-side matrix framer: recovers (row, col) of each streamed element,
// checks eol/eom framing against the programmed dimensions and drops bad frames.
module matrix_stream_rx
  import macc_stream_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DIM_W     = 10,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 VDD,
  input  logic                 GND,
  input  logic [DIM_W-1:0]     row_max,
  input  logic [DIM_W-1:0]     col_max,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_eol,
  input  logic                 in_eom,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [DIM_W-1:0]     out_row,
  output logic [DIM_W-1:0]     out_col,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 frame_done,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int ELEM_W = DATA_W + 2 * DIM_W + 2;
  localparam logic [DIM_W-1:0]     DIM_ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]     DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  rx_state_e            state_r;
  logic [DIM_W-1:0]     row_r;
  logic [DIM_W-1:0]     col_r;
  logic [DIM_W-1:0]     row_lim_r;
  logic [DIM_W-1:0]     col_lim_r;
  logic [DIM_W-1:0]     lim_row_s;
  logic [DIM_W-1:0]     lim_col_s;
  logic                 accept_s;
  logic                 at_end_s;
  logic                 sof_s;
  logic                 err_s;
  logic                 good_s;
  frm_err_e             code_s;
  logic                 frame_done_r;
  logic                 err_pulse_r;
  frm_err_e             err_code_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic [ELEM_W-1:0]    elem_s;
  logic [ELEM_W-1:0]    out_elem_s;
  logic                 unused_s;

  assign unused_s   = VDD ^ GND;
  assign accept_s   = in_valid && in_ready;
  assign sof_s      = (row_r == DIM_ZERO) && (col_r == DIM_ZERO);
  assign elem_s     = {in_data, row_r, col_r, sof_s, at_end_s};
  assign frame_done = frame_done_r;
  assign err_pulse  = err_pulse_r;
  assign err_code   = err_code_r;
  assign err_cnt    = err_cnt_r;
  assign {out_data, out_row, out_col, out_sof, out_eof} = out_elem_s;

  // Framing check of the offered beat; in IDLE the live limits apply since they latch on this beat.
  always_comb begin
    lim_row_s = row_lim_r;
    lim_col_s = col_lim_r;
    if (state_r == IDLE) begin
      lim_row_s = row_max;
      lim_col_s = col_max;
    end else begin
      lim_row_s = row_lim_r;
      lim_col_s = col_lim_r;
    end
    at_end_s = (row_r == lim_row_s) && (col_r == lim_col_s);
    err_s    = 1'b1;
    code_s   = EOM_EARLY;
    if (in_eom && !at_end_s) begin
      code_s = EOM_EARLY;
    end else if (!in_eom && at_end_s) begin
      code_s = EOM_MISSING;
    end else if (in_eol && (col_r < lim_col_s)) begin
      code_s = EOL_EARLY;
    end else if (!in_eol && (col_r == lim_col_s) && (row_r < lim_row_s)) begin
      code_s = EOL_MISSING;
    end else begin
      err_s = 1'b0;
    end
    good_s = accept_s && !err_s && (state_r != RESYNC);
  end

  // Framer state, position counters and error bookkeeping; all advance on accepted beats only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= IDLE;
      row_r        <= DIM_ZERO;
      col_r        <= DIM_ZERO;
      row_lim_r    <= DIM_ZERO;
      col_lim_r    <= DIM_ZERO;
      frame_done_r <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_code_r   <= EOL_EARLY;
      err_cnt_r    <= CNT_ZERO;
    end else begin
      frame_done_r <= 1'b0;
      err_pulse_r  <= 1'b0;
      if (accept_s) begin
        case (state_r)
          IDLE, ACTIVE: begin
            if (state_r == IDLE) begin
              row_lim_r <= row_max;
              col_lim_r <= col_max;
            end
            if (err_s) begin
              err_pulse_r <= 1'b1;
              err_code_r  <= code_s;
              if (err_cnt_r != CNT_MAX) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
              end
              row_r   <= DIM_ZERO;
              col_r   <= DIM_ZERO;
              state_r <= (code_s == EOM_EARLY) ? IDLE : RESYNC;
            end else if (in_eom) begin
              row_r        <= DIM_ZERO;
              col_r        <= DIM_ZERO;
              frame_done_r <= 1'b1;
              state_r      <= IDLE;
            end else if (col_r < lim_col_s) begin
              col_r   <= col_r + DIM_ONE;
              state_r <= ACTIVE;
            end else begin
              row_r   <= row_r + DIM_ONE;
              col_r   <= DIM_ZERO;
              state_r <= ACTIVE;
            end
          end
          RESYNC: begin
            if (in_eom) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  stream_skid_buf #(
    .W(ELEM_W)
  ) u_out_buf (
    .CLK       (CLK),
    .RST       (RST),
    .push_valid(good_s),
    .push_data (elem_s),
    .ready     (in_ready),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (out_elem_s)
  );

endmodule
